// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and tick-accumulator sizing helpers.
package uart_pkg;

    // Receiver states; D0..D7 are consecutive so the FSM can step with +1.
    typedef enum logic [3:0] {
        RX_IDLE  = 4'd0,
        RX_START = 4'd1,
        RX_D0    = 4'd2,
        RX_D1    = 4'd3,
        RX_D2    = 4'd4,
        RX_D3    = 4'd5,
        RX_D4    = 4'd6,
        RX_D5    = 4'd7,
        RX_D6    = 4'd8,
        RX_D7    = 4'd9,
        RX_STOP  = 4'd10,
        RX_BREAK = 4'd11
    } rx_state_t;

    localparam int unsigned OVERSAMPLING_DEFAULT = 8;
    localparam int unsigned OS_W = $clog2(OVERSAMPLING_DEFAULT);

    // Fractional bits kept below the integer clk/rate ratio in the phase accumulator.
    localparam int unsigned ACC_FRAC_BITS = 8;

    // Accumulator width: enough integer bits for the clk/rate ratio plus fraction.
    function automatic int unsigned calc_acc_w(input longint unsigned clk_hz,
                                               input longint unsigned rate_hz);
        longint unsigned ratio;
        ratio = (clk_hz + rate_hz - 64'd1) / rate_hz;
        return 32'($clog2(ratio)) + ACC_FRAC_BITS;
    endfunction

    // Per-clock increment: rate/clk scaled to the accumulator width, rounded.
    function automatic int unsigned calc_acc_inc(input longint unsigned clk_hz,
                                                 input longint unsigned rate_hz);
        longint unsigned w;
        w = 64'(calc_acc_w(clk_hz, rate_hz));
        return 32'(((rate_hz << w) + (clk_hz >> 1)) / clk_hz);
    endfunction

endpackage

// File: rtl/uart_oversample_tick_gen.sv
// Phase-accumulator tick generator: one-clk pulse at Rate on average.
module uart_oversample_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Rate         = 921600
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned AccW   = calc_acc_w(64'(ClkFrequency), 64'(Rate));
    localparam int unsigned AccInc = calc_acc_inc(64'(ClkFrequency), 64'(Rate));
    localparam int unsigned SumW   = AccW + 1;

    logic [AccW-1:0] acc_q, acc_d;
    logic            tick_q, tick_d;
    logic [SumW-1:0] sum;

    // Accumulate and take the carry out as the tick.
    always_comb begin
        sum    = {1'b0, acc_q} + SumW'(AccInc);
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (enable) begin
            acc_d  = sum[AccW-1:0];
            tick_d = sum[AccW];
        end
    end

    // Accumulator and registered tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1 UART receiver with majority filter, framing-error and idle/end-of-packet detection.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = OVERSAMPLING_DEFAULT,
    parameter int unsigned IdleBits     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_framing_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int unsigned OsW     = $clog2(Oversampling);
    localparam int unsigned HalfOs  = Oversampling / 2;
    localparam int unsigned IdleCnt = IdleBits * Oversampling;
    localparam int unsigned GapW    = $clog2(IdleCnt + 1);

    localparam logic [3:0] ST_IDLE  = RX_IDLE;
    localparam logic [3:0] ST_START = RX_START;
    localparam logic [3:0] ST_D0    = RX_D0;
    localparam logic [3:0] ST_D1    = RX_D1;
    localparam logic [3:0] ST_D2    = RX_D2;
    localparam logic [3:0] ST_D3    = RX_D3;
    localparam logic [3:0] ST_D4    = RX_D4;
    localparam logic [3:0] ST_D5    = RX_D5;
    localparam logic [3:0] ST_D6    = RX_D6;
    localparam logic [3:0] ST_D7    = RX_D7;
    localparam logic [3:0] ST_STOP  = RX_STOP;
    localparam logic [3:0] ST_BREAK = RX_BREAK;

    // Reject clocks too slow to oversample reliably and unsupported ratios.
    if (64'(ClkFrequency) < 64'(Baud) * 64'(Oversampling) * 64'd2) begin : g_clk_too_slow
        $error("uart_rx_oversampled: ClkFrequency must be >= 2*Baud*Oversampling");
    end
    if (Oversampling < 4 || Oversampling > 16 ||
        (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
        $error("uart_rx_oversampled: Oversampling must be a power of two in 4..16");
    end

    logic os_tick;

    uart_oversample_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Rate         (Baud * Oversampling)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b1),
        .tick   (os_tick)
    );

    logic            sync1_q, sync2_q;
    logic [2:0]      filt_q;
    logic            rxs;
    logic [3:0]      state_q, state_d;
    logic [OsW-1:0]  oscnt_q, oscnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            idle_q, idle_d;
    logic            eop_q, eop_d;
    logic            got_q, got_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RxD;
            sync2_q <= sync1_q;
        end
    end

    // Three-sample history taken on each oversample tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 3'b111;
        end else if (os_tick) begin
            filt_q <= {filt_q[1:0], sync2_q};
        end
    end

    assign rxs = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);

    // Frame FSM: find start edge, sample each bit at its centre, check stop bit.
    always_comb begin
        state_d = state_q;
        oscnt_d = oscnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        if (os_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        oscnt_d = '0;
                    end
                end
                ST_START: begin
                    if (oscnt_q == OsW'(HalfOs - 1)) begin
                        oscnt_d = '0;
                        state_d = rxs ? ST_IDLE : ST_D0;
                    end else begin
                        oscnt_d = oscnt_q + OsW'(1);
                    end
                end
                ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
                    oscnt_d = oscnt_q + OsW'(1);
                    if (oscnt_q == {OsW{1'b1}}) begin
                        shift_d = {rxs, shift_q[7:1]};
                        state_d = state_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    oscnt_d = oscnt_q + OsW'(1);
                    if (oscnt_q == {OsW{1'b1}}) begin
                        if (rxs) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Idle-gap counter and end-of-packet detection.
    always_comb begin
        gap_d = gap_q;
        if (!rxs) begin
            gap_d = '0;
        end else if (os_tick && state_q == ST_IDLE && gap_q != GapW'(IdleCnt)) begin
            gap_d = gap_q + GapW'(1);
        end
        idle_d = (gap_d == GapW'(IdleCnt));
        eop_d  = idle_d & ~idle_q & got_q;
        got_d  = got_q;
        if (eop_d) begin
            got_d = 1'b0;
        end else if (ready_d) begin
            got_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            oscnt_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            gap_q   <= '0;
            idle_q  <= 1'b0;
            eop_q   <= 1'b0;
            got_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            oscnt_q <= oscnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            gap_q   <= gap_d;
            idle_q  <= idle_d;
            eop_q   <= eop_d;
            got_q   <= got_d;
        end
    end

    assign RxD_data          = data_q;
    assign RxD_data_ready    = ready_q;
    assign RxD_framing_error = ferr_q;
    assign RxD_idle          = idle_q;
    assign RxD_endofpacket   = eop_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at 1.8432 MHz / 115200 baud / 8x (16 clk per bit).
module tb_uart_rx_oversampled;

    localparam int BIT_CLK = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_framing_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .ClkFrequency (1843200),
        .Baud         (115200),
        .Oversampling (8),
        .IdleBits     (10)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .RxD               (RxD),
        .RxD_data          (RxD_data),
        .RxD_data_ready    (RxD_data_ready),
        .RxD_framing_error (RxD_framing_error),
        .RxD_idle          (RxD_idle),
        .RxD_endofpacket   (RxD_endofpacket)
    );

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int n_rdy = 0;
    int n_ferr = 0;
    int n_eop = 0;
    int n_wide = 0;
    int n_both = 0;
    int rdy_cyc = 0;
    int eop_cyc = 0;
    logic prev_rdy = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] got_q[$];

    // Strobe monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (RxD_data_ready === 1'b1) begin
            n_rdy++;
            rdy_cyc = cyc;
            got_q.push_back(RxD_data);
            if (prev_rdy) n_wide++;
            if (RxD_framing_error === 1'b1 || RxD_endofpacket === 1'b1) n_both++;
        end
        if (RxD_framing_error === 1'b1) begin
            n_ferr++;
            if (prev_ferr) n_wide++;
        end
        if (RxD_endofpacket === 1'b1) begin
            n_eop++;
            eop_cyc = cyc;
        end
        prev_rdy  = (RxD_data_ready === 1'b1);
        prev_ferr = (RxD_framing_error === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int per(input int i, input int adj);
        return BIT_CLK + (((i % 2) == 1) ? adj : 0);
    endfunction

    // Drive one frame; adj skews odd-numbered bit periods by +/-1 clk (about +/-3%).
    task automatic send_frame(input logic [7:0] b, input int nstop, input logic stop_bit, input int adj);
        RxD = 1'b0;
        wait_clk(per(0, adj));
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_clk(per(i + 1, adj));
        end
        for (int i = 0; i < nstop; i++) begin
            RxD = (i == 0) ? stop_bit : 1'b1;
            wait_clk(per(9 + i, adj));
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
    endfunction

    initial begin
        int r0;
        int f0;
        int e0;
        int start_cyc;
        logic [7:0] t2_exp [4];
        t2_exp = '{8'h55, 8'hA3, 8'h00, 8'hFF};

        // Reset and idle line.
        rst = 1'b1;
        RxD = 1'b1;
        wait_clk(3);
        chk("rst_data", 32'(RxD_data), 32'h00);
        chk("rst_ready", 32'(RxD_data_ready), 32'h0);
        chk("rst_ferr", 32'(RxD_framing_error), 32'h0);
        chk("rst_idle", 32'(RxD_idle), 32'h0);
        chk("rst_eop", 32'(RxD_endofpacket), 32'h0);
        rst = 1'b0;
        wait_clk(150);
        chk("idle_early", 32'(RxD_idle), 32'h0);
        wait_clk(20);
        chk("idle_late", 32'(RxD_idle), 32'h1);
        wait_clk(30);
        chk("t1_ready_cnt", 32'(n_rdy), 32'd0);
        chk("t1_ferr_cnt", 32'(n_ferr), 32'd0);
        chk("t1_eop_cnt", 32'(n_eop), 32'd0);

        // Four back-to-back frames with two stop bits.
        r0 = n_rdy; f0 = n_ferr; e0 = n_eop;
        got_q.delete();
        start_cyc = cyc;
        send_frame(8'h55, 2, 1'b1, 0);
        chk_range("t2_latency", rdy_cyc - start_cyc, 150, 168);
        send_frame(8'hA3, 2, 1'b1, 0);
        send_frame(8'h00, 2, 1'b1, 0);
        send_frame(8'hFF, 2, 1'b1, 0);
        chk("t2_ready_cnt", 32'(n_rdy - r0), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_data", got_at(i), 32'(t2_exp[i]));
        chk("t2_data_held", 32'(RxD_data), 32'hFF);
        chk("t2_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        wait_clk(300);
        chk("t2_eop_cnt", 32'(n_eop - e0), 32'd1);
        chk_range("t2_eop_delay", eop_cyc - rdy_cyc, 158, 162);

        // One stop bit immediately followed by the next frame.
        r0 = n_rdy;
        got_q.delete();
        send_frame(8'h3C, 1, 1'b1, 0);
        send_frame(8'hC3, 2, 1'b1, 0);
        wait_clk(40);
        chk("t3_ready_cnt", 32'(n_rdy - r0), 32'd2);
        chk("t3_data0", got_at(0), 32'h3C);
        chk("t3_data1", got_at(1), 32'hC3);
        wait_clk(260);

        // Short low glitch on an idle line.
        r0 = n_rdy; f0 = n_ferr;
        RxD = 1'b0;
        wait_clk(6);
        RxD = 1'b1;
        wait_clk(100);
        chk("t4_ready_cnt", 32'(n_rdy - r0), 32'd0);
        chk("t4_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        chk("t4_data", 32'(RxD_data), 32'hC3);

        // Low stop bit followed by a long break, then a good frame.
        r0 = n_rdy; f0 = n_ferr;
        send_frame(8'h81, 1, 1'b0, 0);
        wait_clk(40 * BIT_CLK);
        RxD = 1'b1;
        wait_clk(48);
        chk("t5_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        chk("t5_ready_cnt", 32'(n_rdy - r0), 32'd0);
        chk("t5_data_kept", 32'(RxD_data), 32'hC3);
        got_q.delete();
        send_frame(8'h42, 2, 1'b1, 0);
        wait_clk(20);
        chk("t5_ready_after", 32'(n_rdy - r0), 32'd1);
        chk("t5_data_after", got_at(0), 32'h42);
        wait_clk(260);

        // Reset during D3 of 0xE7, then a clean frame.
        r0 = n_rdy; f0 = n_ferr;
        RxD = 1'b0;
        wait_clk(BIT_CLK);
        RxD = 1'b1;
        wait_clk(3 * BIT_CLK);
        RxD = 1'b0;
        wait_clk(8);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        RxD = 1'b1;
        chk("t6_rst_data", 32'(RxD_data), 32'h00);
        chk("t6_rst_idle", 32'(RxD_idle), 32'h0);
        wait_clk(60);
        chk("t6_no_ready", 32'(n_rdy - r0), 32'd0);
        chk("t6_no_ferr", 32'(n_ferr - f0), 32'd0);
        got_q.delete();
        send_frame(8'h18, 2, 1'b1, 0);
        wait_clk(20);
        chk("t6_ready_cnt", 32'(n_rdy - r0), 32'd1);
        chk("t6_data", got_at(0), 32'h18);
        chk("t6_data_out", 32'(RxD_data), 32'h18);

        // Sender baud skewed slow and fast.
        r0 = n_rdy;
        got_q.delete();
        send_frame(8'h5A, 2, 1'b1, 1);
        send_frame(8'h5A, 2, 1'b1, -1);
        wait_clk(20);
        chk("t6_skew_cnt", 32'(n_rdy - r0), 32'd2);
        chk("t6_skew_slow", got_at(0), 32'h5A);
        chk("t6_skew_fast", got_at(1), 32'h5A);
        chk("t6_skew_ferr", 32'(n_ferr - f0), 32'd0);

        // Whole-run strobe properties.
        chk("strobe_width", 32'(n_wide), 32'd0);
        chk("strobe_overlap", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
